// File: rtl/hermes_packet_injector_pkg.sv
// hermes_packet_injector_pkg: shared injector state encoding and Hermes header packing.
package hermes_packet_injector_pkg;
  localparam int HERMES_FLIT_W = 32;
  typedef enum logic [1:0] {INJ_IDLE, INJ_HEADER, INJ_SIZE, INJ_PAYLOAD} injector_state_t;
  function automatic logic [HERMES_FLIT_W-1:0] hermes_header(input logic [15:0] target);
    return {{(HERMES_FLIT_W-16){1'b0}}, target};
  endfunction
endpackage

// File: rtl/hermes_packet_injector_skid.sv
// hermes_packet_injector_skid: 2-entry FIFO holding prefetched payload words.
module hermes_packet_injector_skid #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wr, r_rd;
  logic [1:0]   r_count;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end
  assign o_head  = r_mem[r_rd];
  assign o_full  = r_count == 2'd2;
  assign o_empty = r_count == 2'd0;
  assign o_count = r_count;
endmodule

// File: rtl/hermes_packet_injector.sv
// hermes_packet_injector: streams header, size and LEN prefetched memory words into a Hermes router port.
module hermes_packet_injector
  import hermes_packet_injector_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int LEN_W     = 16,
  parameter int ADDR_W    = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [15:0]          target_i,
  input  logic [ADDR_W-1:0]    src_addr_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_en_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [FLIT_SIZE-1:0] mem_data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o
);
  injector_state_t      r_state;
  logic [15:0]          r_target;
  logic [ADDR_W-1:0]    r_src;
  logic [LEN_W-1:0]     r_len, r_req, r_sent;
  logic                 r_inflight, r_done;
  logic                 w_tx, w_xfer, w_pop, w_last, w_room, w_mem_en, w_full, w_empty;
  logic [1:0]           w_count;
  logic [FLIT_SIZE-1:0] w_head;
  hermes_packet_injector_skid #(.W(FLIT_SIZE)) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (mem_data_i),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  assign w_tx   = r_state == INJ_HEADER || r_state == INJ_SIZE || (r_state == INJ_PAYLOAD && !w_empty);
  assign w_xfer = w_tx && credit_i;
  assign w_pop  = w_xfer && r_state == INJ_PAYLOAD;
  assign w_last = (r_sent + LEN_W'(1)) == r_len;
  // An entry popped this cycle makes room for the word returning next cycle, keeping payload bubble-free.
  assign w_room   = w_pop || w_count == 2'd0 || (!w_full && !r_inflight);
  assign w_mem_en = r_state != INJ_IDLE && r_req < r_len && w_room;
  assign mem_en_o   = w_mem_en;
  assign mem_addr_o = r_src + (ADDR_W'(r_req) << 2);
  assign tx_o       = w_tx;
  assign data_o     = !w_tx ? '0 :
                      r_state == INJ_HEADER ? FLIT_SIZE'(hermes_header(r_target)) :
                      r_state == INJ_SIZE ? FLIT_SIZE'(r_len) : w_head;
  assign busy_o = r_state != INJ_IDLE;
  assign done_o = r_done;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= INJ_IDLE;
      r_target   <= '0;
      r_src      <= '0;
      r_len      <= '0;
      r_req      <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_mem_en;
      if (w_mem_en) r_req <= r_req + LEN_W'(1);
      if (w_pop) r_sent <= r_sent + LEN_W'(1);
      case (r_state)
        INJ_IDLE: if (start_i) begin
          r_target <= target_i;
          r_src    <= src_addr_i & ~ADDR_W'(3);
          r_len    <= len_i;
          r_req    <= '0;
          r_sent   <= '0;
          r_state  <= INJ_HEADER;
        end
        INJ_HEADER: if (w_xfer) r_state <= INJ_SIZE;
        INJ_SIZE: if (w_xfer) begin
          r_state <= r_len == '0 ? INJ_IDLE : INJ_PAYLOAD;
          r_done  <= r_len == '0;
        end
        INJ_PAYLOAD: if (w_pop && w_last) begin
          r_state <= INJ_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= INJ_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hermes_packet_injector.sv
// tb_hermes_packet_injector: directed checks of the packet injector against hand-computed flit streams.
module tb_hermes_packet_injector;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] target_i = '0;
  logic [23:0] src_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, mem_en_o, tx_o;
  logic [23:0] mem_addr_o;
  logic [31:0] mem_data_i = '0;
  logic        credit_i = 1'b1;
  logic [31:0] data_o;
  logic [31:0] flits[$];
  int          fcyc[$];
  logic [23:0] addrs[$];
  int          dones = 0, stab_err = 0, cyc = 0, n_pass = 0, n_total = 0;
  logic        p_hold = 1'b0, rq_v = 1'b0;
  logic [31:0] p_data = '0;
  logic [23:0] rq_a = '0;

  hermes_packet_injector dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .target_i(target_i),
    .src_addr_i(src_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .tx_o(tx_o), .credit_i(credit_i), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memf(input logic [23:0] a);
    return {8'hA5, a};
  endfunction

  always @(negedge clk_i) begin
    cyc++;
    rq_v = rst_ni && mem_en_o;
    rq_a = mem_addr_o;
    if (!rst_ni) p_hold = 1'b0;
    else begin
      if (tx_o && credit_i) begin
        flits.push_back(data_o);
        fcyc.push_back(cyc);
      end
      if (mem_en_o) addrs.push_back(mem_addr_o);
      if (done_o) dones++;
      if (p_hold && (!tx_o || data_o !== p_data)) stab_err++;
      p_hold = tx_o && !credit_i;
      p_data = data_o;
    end
  end

  always @(posedge clk_i) mem_data_i <= rq_v ? memf(rq_a) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_pkt(input logic [15:0] t, input logic [23:0] s, input logic [15:0] l);
    flits.delete();
    fcyc.delete();
    addrs.delete();
    dones = 0;
    target_i = t;
    src_addr_i = s;
    len_i = l;
    start_i = 1'b1;
    @(posedge clk_i);
    #2 start_i = 1'b0;
  endtask

  task automatic run(input int max, input bit tog);
    int n = 0;
    while (dones == 0 && n < max) begin
      @(posedge clk_i);
      #2 if (tog) credit_i = ~credit_i;
      n++;
    end
    check("done_in_time", 32'(dones != 0), 32'd1);
    credit_i = 1'b1;
    repeat (2) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en_o), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
    check({tag, "_tx"}, 32'(tx_o), 32'd0);
    check({tag, "_data"}, data_o, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #2 check_outputs_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #2;
    // 1) basic packet, back-to-back flits
    start_pkt(16'h0102, 24'h000100, 16'd3);
    check("t1_busy", 32'(busy_o), 32'd1);
    run(40, 1'b0);
    check("t1_count", 32'(flits.size()), 32'd5);
    check("t1_header", flits[0], 32'h0000_0102);
    check("t1_size", flits[1], 32'd3);
    check("t1_w0", flits[2], 32'hA500_0100);
    check("t1_w1", flits[3], 32'hA500_0104);
    check("t1_w2", flits[4], 32'hA500_0108);
    check("t1_no_bubble", 32'(fcyc[4] - fcyc[0]), 32'd4);
    check("t1_dones", 32'(dones), 32'd1);
    check("t1_idle", 32'(busy_o), 32'd0);
    // 2) empty payload
    start_pkt(16'h0203, 24'h000180, 16'd0);
    run(40, 1'b0);
    check("t2_count", 32'(flits.size()), 32'd2);
    check("t2_header", flits[0], 32'h0000_0203);
    check("t2_size", flits[1], 32'd0);
    check("t2_no_reads", 32'(addrs.size()), 32'd0);
    check("t2_dones", 32'(dones), 32'd1);
    // 3) credit toggling every cycle
    start_pkt(16'h0405, 24'h000200, 16'd8);
    stab_err = 0;
    run(200, 1'b1);
    check("t3_count", 32'(flits.size()), 32'd10);
    check("t3_header", flits[0], 32'h0000_0405);
    check("t3_size", flits[1], 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_w%0d", i), flits[i+2], memf(24'(32'h200 + 4*i)));
    check("t3_stable", 32'(stab_err), 32'd0);
    check("t3_reads", 32'(addrs.size()), 32'd8);
    check("t3_dones", 32'(dones), 32'd1);
    // 4) start while busy is ignored
    start_pkt(16'h0304, 24'h000300, 16'd2);
    target_i = 16'h0999;
    src_addr_i = 24'h000900;
    len_i = 16'd7;
    start_i = 1'b1;
    repeat (2) begin
      @(posedge clk_i);
      #2;
    end
    start_i = 1'b0;
    run(40, 1'b0);
    repeat (5) begin
      @(posedge clk_i);
      #2;
    end
    check("t4_count", 32'(flits.size()), 32'd4);
    check("t4_header", flits[0], 32'h0000_0304);
    check("t4_size", flits[1], 32'd2);
    check("t4_w0", flits[2], 32'hA500_0300);
    check("t4_w1", flits[3], 32'hA500_0304);
    check("t4_dones", 32'(dones), 32'd1);
    // 5) address wrap
    start_pkt(16'h0001, 24'hFFFFF8, 16'd4);
    run(40, 1'b0);
    check("t5_reads", 32'(addrs.size()), 32'd4);
    check("t5_a0", 32'(addrs[0]), 32'h00FF_FFF8);
    check("t5_a1", 32'(addrs[1]), 32'h00FF_FFFC);
    check("t5_a2", 32'(addrs[2]), 32'h0000_0000);
    check("t5_a3", 32'(addrs[3]), 32'h0000_0004);
    check("t5_w2", flits[4], 32'hA500_0000);
    check("t5_w3", flits[5], 32'hA500_0004);
    // 6) async reset mid-payload, then fresh packet
    start_pkt(16'h0505, 24'h000500, 16'd5);
    for (int n = 0; n < 40 && flits.size() < 4; n++) begin
      @(posedge clk_i);
      #2;
    end
    check("t6_reach", 32'(flits.size()), 32'd4);
    check("t6_busy_pre", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1 check_outputs_zero("t6_rst");
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #2;
    start_pkt(16'h0606, 24'h000600, 16'd2);
    run(40, 1'b0);
    check("t6_count", 32'(flits.size()), 32'd4);
    check("t6_header", flits[0], 32'h0000_0606);
    check("t6_size", flits[1], 32'd2);
    check("t6_w0", flits[2], 32'hA500_0600);
    check("t6_w1", flits[3], 32'hA500_0604);
    check("t6_dones", 32'(dones), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
